// File: rtl/predictor_ctrl.sv
// rtl/predictor_ctrl.sv - 2-bit BHT controller: init sweep, update FIFO, shared read-port arbitration
`timescale 1ns/1ps
module predictor_ctrl #(
    parameter int         INDEX_WIDTH = 12,
    parameter int         QUEUE_LOG   = 2,
    parameter logic [1:0] INIT_STATE  = 2'b01
) (
    input  logic                   clockIn,
    input  logic                   resetIn,
    input  logic                   lookupValid,
    input  logic [31:0]            lookupAddr,
    output logic                   lookupReady,
    output logic                   predictValid,
    output logic                   predictJump,
    input  logic                   updateValid,
    input  logic [31:0]            updateAddr,
    input  logic                   updateTaken,
    output logic                   updateReady,
    output logic                   busy,
    output logic                   tblReadEn,
    output logic [INDEX_WIDTH-1:0] tblReadIdx,
    input  logic [1:0]             tblReadData,
    output logic                   tblWriteEn,
    output logic [INDEX_WIDTH-1:0] tblWriteIdx,
    output logic [1:0]             tblWriteData
);
    localparam int                     DEPTH    = 1 << QUEUE_LOG;
    localparam logic [QUEUE_LOG:0]     FULL_CNT = (QUEUE_LOG+1)'(DEPTH);
    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = '1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] sweep_idx_q, sweep_idx_d;
    logic [INDEX_WIDTH-1:0] fifo_idx_q [DEPTH];
    logic [INDEX_WIDTH-1:0] fifo_idx_d [DEPTH];
    logic [DEPTH-1:0]       fifo_taken_q, fifo_taken_d;
    logic [QUEUE_LOG-1:0]   wr_ptr_q, wr_ptr_d;
    logic [QUEUE_LOG-1:0]   rd_ptr_q, rd_ptr_d;
    logic [QUEUE_LOG:0]     count_q, count_d;
    logic                   update_ready_q, update_ready_d;
    logic                   rmw_valid_q, rmw_valid_d;
    logic [INDEX_WIDTH-1:0] rmw_idx_q, rmw_idx_d;
    logic                   rmw_taken_q, rmw_taken_d;
    logic                   lk_valid_q, lk_valid_d;
    logic                   fwd_hit_q, fwd_hit_d;
    logic [1:0]             fwd_data_q, fwd_data_d;

    logic                   in_run, fifo_full, fifo_empty;
    logic                   grant_head, grant_lookup, push, pop;
    logic [INDEX_WIDTH-1:0] lookup_idx, update_idx, head_idx;
    logic [1:0]             rd_data, rmw_new;
    logic                   unused_addr_bits;

    assign lookup_idx = lookupAddr[INDEX_WIDTH+1:2];
    assign update_idx = updateAddr[INDEX_WIDTH+1:2];
    assign head_idx   = fifo_idx_q[rd_ptr_q];
    assign unused_addr_bits = ^{lookupAddr[31:INDEX_WIDTH+2], lookupAddr[1:0],
                                updateAddr[31:INDEX_WIDTH+2], updateAddr[1:0]};

    // A full FIFO steals the port from lookups so updates can never deadlock.
    always_comb begin
        in_run       = (state_q == ST_RUN);
        fifo_full    = (count_q == FULL_CNT);
        fifo_empty   = (count_q == '0);
        grant_head   = in_run && (fifo_full || (!lookupValid && !fifo_empty));
        grant_lookup = in_run && !fifo_full && lookupValid;
        push         = updateValid && update_ready_q;
        pop          = grant_head;
    end

    // The RAM returns pre-write data on a same-cycle collision; substitute the value written then.
    always_comb begin
        rd_data = fwd_hit_q ? fwd_data_q : tblReadData;
        if (rmw_taken_q) begin
            rmw_new = (rd_data == 2'b11) ? 2'b11 : rd_data + 2'b01;
        end else begin
            rmw_new = (rd_data == 2'b00) ? 2'b00 : rd_data - 2'b01;
        end
    end

    assign busy         = !in_run;
    assign lookupReady  = in_run && !fifo_full;
    assign updateReady  = update_ready_q;
    assign predictValid = lk_valid_q;
    assign predictJump  = lk_valid_q && rd_data[1];
    assign tblReadEn    = grant_head || grant_lookup;
    assign tblReadIdx   = grant_head ? head_idx : lookup_idx;
    assign tblWriteEn   = !in_run || rmw_valid_q;
    assign tblWriteIdx  = in_run ? rmw_idx_q : sweep_idx_q;
    assign tblWriteData = in_run ? rmw_new : INIT_STATE;

    always_comb begin
        state_d      = state_q;
        sweep_idx_d  = sweep_idx_q;
        fifo_idx_d   = fifo_idx_q;
        fifo_taken_d = fifo_taken_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;

        if (state_q == ST_INIT) begin
            sweep_idx_d = sweep_idx_q + 1'b1;
            if (sweep_idx_q == LAST_IDX) begin
                state_d = ST_RUN;
            end
        end

        if (push) begin
            fifo_idx_d[wr_ptr_q]   = update_idx;
            fifo_taken_d[wr_ptr_q] = updateTaken;
            wr_ptr_d               = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        update_ready_d = (count_d != FULL_CNT) && (state_d == ST_RUN);
        rmw_valid_d    = grant_head;
        rmw_idx_d      = head_idx;
        rmw_taken_d    = fifo_taken_q[rd_ptr_q];
        lk_valid_d     = grant_lookup;
        fwd_hit_d      = tblReadEn && tblWriteEn && (tblReadIdx == tblWriteIdx);
        fwd_data_d     = tblWriteData;
    end

    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            state_q        <= ST_INIT;
            sweep_idx_q    <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            update_ready_q <= 1'b0;
            rmw_valid_q    <= 1'b0;
            lk_valid_q     <= 1'b0;
            fwd_hit_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            sweep_idx_q    <= sweep_idx_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            update_ready_q <= update_ready_d;
            rmw_valid_q    <= rmw_valid_d;
            lk_valid_q     <= lk_valid_d;
            fwd_hit_q      <= fwd_hit_d;
        end
    end

    always_ff @(posedge clockIn) begin
        fifo_idx_q   <= fifo_idx_d;
        fifo_taken_q <= fifo_taken_d;
        rmw_idx_q    <= rmw_idx_d;
        rmw_taken_q  <= rmw_taken_d;
        fwd_data_q   <= fwd_data_d;
    end
endmodule

// File: tb/tb_predictor_ctrl.sv
// tb/tb_predictor_ctrl.sv - scoreboard bench for predictor_ctrl against a grant-order table model
`timescale 1ns/1ps
module tb_predictor_ctrl;
    localparam int         IW     = 4;
    localparam int         N      = 1 << IW;
    localparam logic [1:0] INIT_V = 2'b01;

    logic          clockIn = 1'b0;
    logic          resetIn, lookupValid, updateValid, updateTaken;
    logic [31:0]   lookupAddr, updateAddr;
    logic          lookupReady, predictValid, predictJump, updateReady, busy;
    logic          tblReadEn, tblWriteEn;
    logic [IW-1:0] tblReadIdx, tblWriteIdx;
    logic [1:0]    tblReadData, tblWriteData;

    always #5 clockIn = ~clockIn;

    predictor_ctrl #(.INDEX_WIDTH(IW), .QUEUE_LOG(2), .INIT_STATE(INIT_V)) dut (
        .clockIn(clockIn), .resetIn(resetIn),
        .lookupValid(lookupValid), .lookupAddr(lookupAddr), .lookupReady(lookupReady),
        .predictValid(predictValid), .predictJump(predictJump),
        .updateValid(updateValid), .updateAddr(updateAddr), .updateTaken(updateTaken),
        .updateReady(updateReady), .busy(busy),
        .tblReadEn(tblReadEn), .tblReadIdx(tblReadIdx), .tblReadData(tblReadData),
        .tblWriteEn(tblWriteEn), .tblWriteIdx(tblWriteIdx), .tblWriteData(tblWriteData)
    );

    // External BHT RAM: registered read, old data on same-cycle write.
    logic [1:0] ram [N];
    always @(posedge clockIn) begin
        if (tblReadEn)  tblReadData <= ram[tblReadIdx];
        if (tblWriteEn) ram[tblWriteIdx] <= tblWriteData;
    end

    typedef struct { int due; logic [IW-1:0] idx; logic [1:0] val; } wr_exp_t;
    typedef struct { int due; logic jump; } pr_exp_t;
    typedef struct { logic [IW-1:0] idx; logic taken; } upd_t;

    wr_exp_t    wq[$];
    pr_exp_t    pq[$];
    upd_t       pend[$];
    logic [1:0] mdl [N];
    int         init_left = 0;
    bit         model_ok = 1'b0, exp_uready = 1'b0;
    bit         cur_chk = 1'b0, cur_busy, cur_lready, cur_uready;
    bit         done_req = 1'b0;
    int         cyc = 0;
    int         wrd = 0, prd = 0;
    int         total = 0, bad = 0;

    function automatic logic [1:0] next_ctr(input logic [1:0] c, input logic t);
        int v;
        v = int'(c) + (t ? 1 : -1);
        if (v > 3) v = 3;
        if (v < 0) v = 0;
        return 2'(v);
    endfunction

    // Model: updates take effect in grant order; a lookup sees every update granted before it.
    task automatic step(input bit rst, input bit lv, input logic [31:0] la,
                        input bit uv, input logic [31:0] ua, input bit ut);
        upd_t    u;
        wr_exp_t w;
        pr_exp_t p;
        logic [IW-1:0] li;
        cur_chk    = model_ok;
        cur_busy   = (init_left > 0);
        cur_lready = (init_left == 0) && (pend.size() < 4);
        cur_uready = exp_uready;
        if (rst) begin
            while (wq.size() > wrd && wq[wq.size()-1].due > cyc) void'(wq.pop_back());
            while (pq.size() > prd && pq[pq.size()-1].due > cyc) void'(pq.pop_back());
            pend.delete();
            for (int i = 0; i < N; i++) begin
                mdl[i] = INIT_V;
                w.due = cyc + 1 + i; w.idx = IW'(i); w.val = INIT_V;
                wq.push_back(w);
            end
            init_left  = N;
            exp_uready = 1'b0;
            model_ok   = 1'b1;
        end else begin
            if (init_left == 0) begin
                if (pend.size() == 4 || (!lv && pend.size() > 0)) begin
                    u = pend.pop_front();
                    mdl[u.idx] = next_ctr(mdl[u.idx], u.taken);
                    w.due = cyc + 1; w.idx = u.idx; w.val = mdl[u.idx];
                    wq.push_back(w);
                end else if (lv) begin
                    li = la[IW+1:2];
                    p.due = cyc + 1; p.jump = mdl[li][1];
                    pq.push_back(p);
                end
            end
            if (uv && exp_uready) begin
                u.idx = ua[IW+1:2]; u.taken = ut;
                pend.push_back(u);
            end
            if (init_left > 0) init_left--;
            exp_uready = (init_left == 0) && (pend.size() < 4);
        end
    endtask

    task automatic drv(input bit rst, input bit lv, input logic [31:0] la,
                       input bit uv, input logic [31:0] ua, input bit ut);
        @(posedge clockIn);
        cyc++;
        #1;
        resetIn = rst; lookupValid = lv; lookupAddr = la;
        updateValid = uv; updateAddr = ua; updateTaken = ut;
        step(rst, lv, la, uv, ua, ut);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: consumes scoreboard entries whenever the DUT is due to present them.
    always @(negedge clockIn) begin
        if (done_req) begin
            check("writes_drained", 32'(wq.size() - wrd), 32'd0);
            check("predicts_drained", 32'(pq.size() - prd), 32'd0);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end else if (cur_chk) begin
            check("busy", 32'(busy), 32'(cur_busy));
            check("lookup_ready", 32'(lookupReady), 32'(cur_lready));
            check("update_ready", 32'(updateReady), 32'(cur_uready));
            if (wrd < wq.size() && wq[wrd].due == cyc) begin
                check("write_en", 32'(tblWriteEn), 32'd1);
                check("write_idx", 32'(tblWriteIdx), 32'(wq[wrd].idx));
                check("write_data", 32'(tblWriteData), 32'(wq[wrd].val));
                wrd++;
            end else begin
                check("write_idle", 32'(tblWriteEn), 32'd0);
            end
            if (prd < pq.size() && pq[prd].due == cyc) begin
                check("predict_valid", 32'(predictValid), 32'd1);
                check("predict_jump", 32'(predictJump), 32'(pq[prd].jump));
                prd++;
            end else begin
                check("predict_idle", 32'({predictValid, predictJump}), 32'd0);
            end
        end
    end

    initial begin
        int          n, idx;
        bit          r, lv, hv, ht;
        logic [31:0] la, ha;
        resetIn = 1'b1; lookupValid = 1'b0; lookupAddr = '0;
        updateValid = 1'b0; updateAddr = '0; updateTaken = 1'b0;
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        drv(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        idle(N + 2);

        drv(1'b0, 1'b1, 32'h8, 1'b0, 32'h0, 1'b0);
        idle(2);

        drv(1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 1'b1);
        drv(1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 1'b1);
        drv(1'b0, 1'b1, 32'h8, 1'b0, 32'h0, 1'b0);
        idle(3);
        drv(1'b0, 1'b1, 32'h8, 1'b0, 32'h0, 1'b0);
        idle(2);

        for (int i = 0; i < 4; i++) drv(1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 1'b1);
        for (int i = 0; i < 5; i++) drv(1'b0, 1'b0, 32'h0, 1'b1, 32'h14, 1'b0);
        idle(4);
        drv(1'b0, 1'b1, 32'h8, 1'b0, 32'h0, 1'b0);
        drv(1'b0, 1'b1, 32'h14, 1'b0, 32'h0, 1'b0);
        idle(2);

        n = 0;
        for (int k = 0; k < 14; k++) begin
            drv(1'b0, 1'b1, 32'h30, 1'b1, 32'(n % 4) << 2, 1'(n % 2));
            if (updateReady) n++;
        end
        idle(6);

        drv(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        idle(7);
        drv(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        idle(N + 2);
        drv(1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 1'b1);
        drv(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        idle(N + 2);
        drv(1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 1'b1);
        idle(1);
        drv(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        idle(N + 2);
        for (int i = 0; i < 4; i++) drv(1'b0, 1'b1, 32'h4, 1'b1, 32'h4 * i, 1'b1);
        drv(1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 1'b0);
        idle(N + 4);

        hv = 1'b0; ha = '0; ht = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            r   = ($urandom_range(0, 299) == 0);
            lv  = 1'($urandom_range(0, 1));
            idx = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
            la  = ($urandom & 32'hFFFF_FFC3) | (32'(idx) << 2);
            if (!hv && $urandom_range(0, 2) != 0) begin
                hv  = 1'b1;
                idx = int'($urandom_range(0, 3));
                ha  = ($urandom & 32'hFFFF_FFC3) | (32'(idx) << 2);
                ht  = 1'($urandom_range(0, 1));
            end
            drv(r, lv, la, hv, ha, ht);
            if (hv && updateReady) hv = 1'b0;
        end
        idle(N + 8);
        done_req = 1'b1;
    end
endmodule
